cacheline_burst_adapter: RTL and testbench
==========================================

# cacheline_burst_adapter

Converts the single-beat 256-bit line transactions issued by the eviction write buffer (its pmem_* port) into 4-beat, 64-bit burst transactions for physical memory. The block sits between the eviction write buffer and the memory model. It is the last stage of the memory hierarchy. It presents a line-granular request/response port upstream and a beat-granular burst port downstream.

## Interface
- LINE_WIDTH, 256, bits per cache line (upstream data width)
- BEAT_WIDTH, 64, bits per memory beat; BEATS = LINE_WIDTH/BEAT_WIDTH = 4
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- line_address  input  32  line request address; bits [4:0] ignored
- line_read  input  1  line read request, held until line_resp
- line_write  input  1  line write request, held until line_resp
- line_wdata  input  256  write line, valid while line_write
- line_rdata  output  256  assembled read line (registered)
- line_resp  output  1  one-cycle completion pulse
- burst_address  output  32  {line_address[31:5], 5'b0}, latched at accept
- burst_read  output  1  burst read request, held for the whole burst
- burst_write  output  1  burst write request, held for the whole burst
- burst_wdata  output  64  current write beat
- burst_rdata  input  64  read beat, valid when burst_resp
- burst_resp  input  1  one beat transferred this cycle

## Operation
- State machine with 4 states: IDLE, READ_BURST, WRITE_BURST, DONE.
- IDLE:
  - If line_write is high: latch line_wdata and the aligned address, clear the beat counter, go to WRITE_BURST.
  - Else if line_read is high: latch the address, clear the beat counter, go to READ_BURST.
  - If both are high, write wins. Read is then served as a fresh request after DONE.
- READ_BURST:
  - burst_read=1.
  - Each cycle with burst_resp=1 stores burst_rdata into line_rdata[count*64 +: 64] and increments count.
  - The beat with count==3 moves the FSM to DONE.
- WRITE_BURST:
  - burst_write=1; burst_wdata = latched_line[count*64 +: 64].
  - Each burst_resp increments count.
  - The beat with count==3 moves the FSM to DONE.
- DONE:
  - line_resp=1 for exactly this cycle, then return to IDLE.
  - Requests seen in DONE are ignored. The requester drops its request the cycle after line_resp.
- Beat order is fixed ascending: beat 0 carries bits [63:0].
- count is 2 bits and saturates by state exit, never wraps within a burst.
- burst_resp in IDLE or DONE is ignored: no state, counter or data change.
- line_address, line_wdata and line_read/line_write changes after accept do not affect the burst in flight.

## Timing
- Reset values:
  - state=IDLE, count=0.
  - line_rdata=0, line_resp=0.
  - burst_read=0, burst_write=0.
  - burst_address=0, burst_wdata=0.
- Reset asserted mid-burst aborts immediately (asynchronous). burst_read and burst_write drop without waiting for a clock. No line_resp is produced for the aborted request.
- Accept at edge T0 (IDLE with a request sampled). burst_read or burst_write is high from T0+1.
- Minimum latency, with burst_resp high on 4 consecutive cycles T1..T4: line_resp=1 during T5. Request to response is 5 cycles after accept.
- Wait cycles (burst_resp=0) between beats stretch latency 1:1. burst_address and the request hold steady throughout.
- line_rdata becomes valid no later than the line_resp cycle. It holds until the next read's first beat.
- burst_wdata changes only on the edge following a burst_resp beat.
- Back-to-back: a new request held through DONE is accepted in the following IDLE cycle. There is 1 idle cycle between bursts.

## Structure
- Package cacheline_burst_pkg holds:
  - the state enum (IDLE, READ_BURST, WRITE_BURST, DONE);
  - LINE_WIDTH, BEAT_WIDTH and BEATS constants;
  - the beat counter width.
- Single module with no sub-module. The beat counter and line register are inline. Estimated size is 150–250 lines of RTL.

## Test plan
- Read, no waits:
  - Stimulus: line_read, line_address=0x0000_1234. Memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - Required: burst_address=0x0000_1220; line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}; line_resp 5 cycles after accept.
- Write with waits:
  - Stimulus: line_write, line_wdata=0xDDDD..CCCC..BBBB..AAAA (64-bit quarters). Memory inserts 2 wait cycles before each beat.
  - Required: burst_wdata shows 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. in order; line_resp 13 cycles after accept.
- Simultaneous line_read and line_write in IDLE:
  - Required: the write burst runs first, then the read burst. There are two separate line_resp pulses.
- Stray burst_resp in IDLE:
  - Required: no state change and line_resp stays 0. A following read still collects exactly 4 beats.
- rst asserted after beat 2 of a read:
  - Required: outputs return to their reset values asynchronously with no line_resp. A new read afterwards completes normally with fresh data.
- Back-to-back reads to 0x100 and 0x200:
  - Required: burst_address changes only at accept. Each line_resp is one cycle wide with correct data.

Source files
------------

// File: rtl/cacheline_burst_pkg.sv
// Shared types and sizing for the line-to-burst memory adapter.
// Beat counter width derives from the beats per line.
package cacheline_burst_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = 64;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ_BURST,
        WRITE_BURST,
        DONE
    } state_e;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Splits 256-bit line reads/writes into 4-beat 64-bit memory bursts.
// All outputs are registered; reset aborts a burst without a response.
module cacheline_burst_adapter
    import cacheline_burst_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           line_address,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [31:0]           burst_address,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    state_e                  state_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic [LINE_WIDTH-1:0]   wline_q;
    logic [LINE_WIDTH-1:0]   rline_q;
    logic                    resp_q;
    logic [31:0]             addr_q;
    logic                    bread_q;
    logic                    bwrite_q;
    logic [BEAT_WIDTH-1:0]   wbeat_q;
    logic [31:0]             addr_d;

    // Line offset bits never reach memory; bursts are line aligned.
    logic unused_offset;
    assign unused_offset = ^line_address[4:0];

    assign count_d = count_q + 1'b1;
    assign addr_d  = {line_address[31:5], 5'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wline_q  <= '0;
            rline_q  <= '0;
            resp_q   <= 1'b0;
            addr_q   <= '0;
            bread_q  <= 1'b0;
            bwrite_q <= 1'b0;
            wbeat_q  <= '0;
        end else begin
            resp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (line_write) begin
                        wline_q  <= line_wdata;
                        wbeat_q  <= line_wdata[BEAT_WIDTH-1:0];
                        addr_q   <= addr_d;
                        count_q  <= '0;
                        bwrite_q <= 1'b1;
                        state_q  <= WRITE_BURST;
                    end else if (line_read) begin
                        addr_q  <= addr_d;
                        count_q <= '0;
                        bread_q <= 1'b1;
                        state_q <= READ_BURST;
                    end
                end
                READ_BURST: begin
                    if (burst_resp) begin
                        rline_q[BEAT_WIDTH*int'(count_q) +: BEAT_WIDTH]
                            <= burst_rdata;
                        if (count_q == LAST_BEAT) begin
                            bread_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            count_q <= count_d;
                        end
                    end
                end
                WRITE_BURST: begin
                    if (burst_resp) begin
                        if (count_q == LAST_BEAT) begin
                            bwrite_q <= 1'b0;
                            resp_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            count_q <= count_d;
                            wbeat_q <= wline_q[BEAT_WIDTH*int'(count_d)
                                               +: BEAT_WIDTH];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign line_rdata    = rline_q;
    assign line_resp     = resp_q;
    assign burst_address = addr_q;
    assign burst_read    = bread_q;
    assign burst_write   = bwrite_q;
    assign burst_wdata   = wbeat_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomized bench for cacheline_burst_adapter with a memory responder
// and a line-level reference model (concatenated beats, latency formula).
module tb_cacheline_burst_adapter;
    import cacheline_burst_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [31:0]           line_address;
    logic                  line_read;
    logic                  line_write;
    logic [LINE_WIDTH-1:0] line_wdata;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic                  line_resp;
    logic [31:0]           burst_address;
    logic                  burst_read;
    logic                  burst_write;
    logic [BEAT_WIDTH-1:0] burst_wdata;
    logic [BEAT_WIDTH-1:0] burst_rdata;
    logic                  burst_resp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cacheline_burst_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .line_address (line_address),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .burst_address(burst_address),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    // Memory model: mem_waits idle cycles before every beat.
    bit          mem_en = 1'b1;
    int          mem_waits = 0;
    int          wcnt = 0;
    int          beat = 0;
    logic [63:0] rd_q[$];
    logic [63:0] wr_log[$];
    logic [31:0] addr_log[$];

    always @(posedge clk) begin
        #1;
        if (mem_en) begin
            if (rst || !(burst_read || burst_write)) begin
                burst_resp = 1'b0;
                wcnt = 0;
                beat = 0;
            end else if (wcnt < mem_waits) begin
                burst_resp = 1'b0;
                wcnt++;
            end else if (beat < BEATS) begin
                burst_resp = 1'b1;
                addr_log.push_back(burst_address);
                if (burst_write) wr_log.push_back(burst_wdata);
                else burst_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : '0;
                beat++;
                wcnt = 0;
            end else begin
                burst_resp = 1'b0;
            end
        end
    end

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] r256();
        return {r64(), r64(), r64(), r64()};
    endfunction

    task automatic wait_resp(output int lat, output bit ok);
        bit started = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!started && (burst_read || burst_write)) started = 1'b1;
            if (started) lat++;
            if (line_resp) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_xact(input bit wr, input logic [31:0] a,
                           input logic [255:0] wd, input logic [255:0] rb,
                           output int lat, output bit ok);
        addr_log.delete();
        wr_log.delete();
        rd_q.delete();
        if (!wr) for (int k = 0; k < BEATS; k++) rd_q.push_back(rb[k*64 +: 64]);
        line_address = a;
        line_wdata   = wd;
        line_write   = wr;
        line_read    = !wr;
        wait_resp(lat, ok);
        line_read  = 1'b0;
        line_write = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl resp=%b rd=%b wr=%b want 0",
                     line_resp, burst_read, burst_write);
        end
        n_checks++;
        if (burst_address !== 32'h0 || burst_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus addr=%h wdata=%h want 0",
                     burst_address, burst_wdata);
        end
        n_checks++;
        if (line_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want 0", line_rdata);
        end
    endtask

    task automatic test_read_nowait();
        int lat; bit ok;
        logic [255:0] exp;
        exp = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        mem_waits = 0;
        do_xact(1'b0, 32'h0000_1234, '0, exp, lat, ok);
        n_checks++;
        if (!ok || lat != 5) begin
            n_fail++;
            $display("FAIL read_lat ok=%b got %0d want 5", ok, lat);
        end
        n_checks++;
        if (line_rdata !== exp) begin
            n_fail++;
            $display("FAIL read_data got %h want %h", line_rdata, exp);
        end
        n_checks++;
        if (addr_log.size() != 4 || addr_log[0] !== 32'h0000_1220
            || addr_log[3] !== 32'h0000_1220) begin
            n_fail++;
            $display("FAIL read_addr n=%0d a0=%h want 4 x 00001220",
                     addr_log.size(), burst_address);
        end
        @(posedge clk); #1;
        n_checks++;
        if (line_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL read_pulse got %b want 0", line_resp);
        end
    endtask

    task automatic test_write_waits();
        int lat; bit ok;
        logic [255:0] wd;
        wd = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        mem_waits = 2;
        do_xact(1'b1, 32'h0000_4ABC, wd, '0, lat, ok);
        n_checks++;
        if (!ok || lat != 13) begin
            n_fail++;
            $display("FAIL write_lat ok=%b got %0d want 13", ok, lat);
        end
        for (int k = 0; k < BEATS; k++) begin
            n_checks++;
            if (wr_log.size() != 4 || wr_log[k] !== wd[k*64 +: 64]) begin
                n_fail++;
                $display("FAIL write_beat%0d got %h want %h", k,
                         (wr_log.size() > k) ? wr_log[k] : 64'hx,
                         wd[k*64 +: 64]);
            end
        end
        n_checks++;
        if (addr_log.size() != 4 || addr_log[2] !== 32'h0000_4AA0) begin
            n_fail++;
            $display("FAIL write_addr got %h want 00004aa0", burst_address);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; bit ok; bit wr; int w;
        logic [31:0] a; logic [255:0] d;
        for (int it = 0; it < 8; it++) begin
            wr = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 3);
            a = $urandom;
            d = r256();
            mem_waits = w;
            do_xact(wr, a, d, d, lat, ok);
            n_checks++;
            if (!ok || lat != 1 + BEATS * (w + 1)) begin
                n_fail++;
                $display("FAIL rand%0d_lat got %0d want %0d", it, lat,
                         1 + BEATS * (w + 1));
            end
            n_checks++;
            if (wr ? (wr_log.size() != 4 ||
                      {wr_log[3], wr_log[2], wr_log[1], wr_log[0]} !== d)
                   : line_rdata !== d) begin
                n_fail++;
                $display("FAIL rand%0d_data wr=%b got %h want %h", it, wr,
                         line_rdata, d);
            end
            n_checks++;
            if (addr_log.size() != 4 || addr_log[1] !== {a[31:5], 5'b0}) begin
                n_fail++;
                $display("FAIL rand%0d_addr got %h want %h", it,
                         burst_address, {a[31:5], 5'b0});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_simultaneous();
        int lat; bit ok1; bit ok2;
        logic [255:0] wd; logic [255:0] rb;
        wd = r256();
        rb = r256();
        mem_waits = 1;
        addr_log.delete();
        wr_log.delete();
        rd_q.delete();
        for (int k = 0; k < BEATS; k++) rd_q.push_back(rb[k*64 +: 64]);
        line_address = 32'h0000_8000;
        line_wdata   = wd;
        line_write   = 1'b1;
        line_read    = 1'b1;
        wait_resp(lat, ok1);
        line_write = 1'b0;
        n_checks++;
        if (!ok1 || wr_log.size() != 4 || rd_q.size() != 4) begin
            n_fail++;
            $display("FAIL simul_first ok=%b wbeats=%0d rleft=%0d want 1/4/4",
                     ok1, wr_log.size(), rd_q.size());
        end
        wait_resp(lat, ok2);
        line_read = 1'b0;
        n_checks++;
        if (!ok2 || line_rdata !== rb) begin
            n_fail++;
            $display("FAIL simul_read ok=%b got %h want %h", ok2, line_rdata, rb);
        end
        n_checks++;
        if (wr_log.size() != 4 ||
            {wr_log[3], wr_log[2], wr_log[1], wr_log[0]} !== wd) begin
            n_fail++;
            $display("FAIL simul_write beats=%0d want %h", wr_log.size(), wd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stray();
        int lat; bit ok; bit bad;
        logic [255:0] prev; logic [255:0] rb;
        prev = line_rdata;
        bad = 1'b0;
        mem_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            burst_resp  = 1'b1;
            burst_rdata = r64();
            @(posedge clk); #1;
            if (line_resp || burst_read || burst_write) bad = 1'b1;
        end
        burst_resp = 1'b0;
        mem_en = 1'b1;
        n_checks++;
        if (bad || line_rdata !== prev) begin
            n_fail++;
            $display("FAIL stray_idle bad=%b got %h want %h", bad,
                     line_rdata, prev);
        end
        rb = r256();
        mem_waits = 0;
        do_xact(1'b0, 32'h0000_0040, '0, rb, lat, ok);
        n_checks++;
        if (!ok || lat != 5 || line_rdata !== rb) begin
            n_fail++;
            $display("FAIL stray_read lat=%0d got %h want %h", lat,
                     line_rdata, rb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; bit ok; bit seen;
        logic [255:0] rb;
        rb = r256();
        mem_waits = 0;
        addr_log.delete();
        rd_q.delete();
        for (int k = 0; k < BEATS; k++) rd_q.push_back(rb[k*64 +: 64]);
        line_address = 32'h0000_0300;
        line_read = 1'b1;
        for (int i = 0; i < 50 && addr_log.size() < 3; i++) begin
            @(posedge clk); #2;
        end
        #1 rst = 1'b1;
        line_read = 1'b0;
        #1;
        n_checks++;
        if (burst_read !== 1'b0 || line_resp !== 1'b0 || line_rdata !== '0
            || burst_address !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_async rd=%b resp=%b addr=%h want 0",
                     burst_read, line_resp, burst_address);
        end
        seen = 1'b0;
        @(posedge clk); #3 rst = 1'b0;
        rd_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (line_resp) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL rst_noresp got 1 want 0");
        end
        rb = r256();
        do_xact(1'b0, 32'h0000_0500, '0, rb, lat, ok);
        n_checks++;
        if (!ok || lat != 5 || line_rdata !== rb) begin
            n_fail++;
            $display("FAIL rst_reread lat=%0d got %h want %h", lat,
                     line_rdata, rb);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; bit ok;
        logic [255:0] r1; logic [255:0] r2;
        r1 = r256();
        r2 = r256();
        mem_waits = 0;
        addr_log.delete();
        rd_q.delete();
        for (int k = 0; k < BEATS; k++) rd_q.push_back(r1[k*64 +: 64]);
        for (int k = 0; k < BEATS; k++) rd_q.push_back(r2[k*64 +: 64]);
        line_address = 32'h0000_0100;
        line_read = 1'b1;
        wait_resp(lat, ok);
        line_address = 32'h0000_0200;
        n_checks++;
        if (!ok || line_rdata !== r1) begin
            n_fail++;
            $display("FAIL b2b_first ok=%b got %h want %h", ok, line_rdata, r1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0
            || burst_address !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL b2b_idle resp=%b rd=%b addr=%h want 0/0/00000100",
                     line_resp, burst_read, burst_address);
        end
        @(posedge clk); #1;
        n_checks++;
        if (burst_read !== 1'b1 || burst_address !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL b2b_accept rd=%b addr=%h want 1/00000200",
                     burst_read, burst_address);
        end
        wait_resp(lat, ok);
        line_read = 1'b0;
        n_checks++;
        if (!ok || line_rdata !== r2) begin
            n_fail++;
            $display("FAIL b2b_second ok=%b got %h want %h", ok, line_rdata, r2);
        end
        n_checks++;
        if (addr_log.size() != 8 || addr_log[3] !== 32'h0000_0100
            || addr_log[4] !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL b2b_addrs n=%0d want 8 split 100/200",
                     addr_log.size());
        end
        @(posedge clk); #1;
        n_checks++;
        if (line_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulse got %b want 0", line_resp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        line_address = '0;
        line_read    = 1'b0;
        line_write   = 1'b0;
        line_wdata   = '0;
        burst_rdata  = '0;
        burst_resp   = 1'b0;
        #1;
        test_reset();
        @(posedge clk); @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        test_read_nowait();
        test_write_waits();
        test_random();
        test_simultaneous();
        test_stray();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
